// File: rtl/val2_encoder.sv
// val2_encoder: iterative search for the 12-bit shift_operand encoding of a 32-bit value
// (rotated imm8 for data-processing, sign-extended 12-bit offset for memory).
module val2_encoder #(
    parameter int ROT_STEPS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        is_mem_command,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [11:0] shift_operand,
    output logic        immediate
);
    typedef enum logic {IDLE, SEARCH} state_t;

    state_t      state, state_nx;
    logic [3:0]  rot, rot_nx;
    logic [31:0] cap, cap_nx;
    logic        mem, mem_nx;
    logic        busy_nx, done_nx, valid_nx, imm_nx;
    logic [11:0] so_nx;
    logic [4:0]  sh;
    logic [63:0] dbl;
    logic [31:0] cand;

    // Rotate-left by 2*rot: the upper half of the doubled word shifted left
    assign sh   = {rot, 1'b0};
    assign dbl  = {cap, cap} << sh;
    assign cand = dbl[63:32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rot           <= '0;
            cap           <= '0;
            mem           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            valid         <= 1'b0;
            shift_operand <= '0;
            immediate     <= 1'b0;
        end else begin
            state         <= state_nx;
            rot           <= rot_nx;
            cap           <= cap_nx;
            mem           <= mem_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            valid         <= valid_nx;
            shift_operand <= so_nx;
            immediate     <= imm_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rot_nx   = rot;
        cap_nx   = cap;
        mem_nx   = mem;
        busy_nx  = busy;
        done_nx  = 1'b0;
        valid_nx = valid;
        so_nx    = shift_operand;
        imm_nx   = immediate;
        if (state == IDLE) begin
            if (start) begin
                cap_nx = value;
                mem_nx = is_mem_command;
                if (is_mem_command) begin
                    done_nx  = 1'b1;
                    imm_nx   = 1'b0;
                    so_nx    = value[11:0];
                    valid_nx = (&value[31:11]) | ~(|value[31:11]);
                end else begin
                    rot_nx   = '0;
                    busy_nx  = 1'b1;
                    state_nx = SEARCH;
                end
            end
        end else if (cand[31:8] == '0) begin
            so_nx    = {rot, cand[7:0]};
            valid_nx = 1'b1;
            imm_nx   = 1'b1;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
        end else if (rot == 4'(ROT_STEPS - 1)) begin
            so_nx    = '0;
            valid_nx = 1'b0;
            imm_nx   = 1'b0;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
        end else begin
            rot_nx = rot + 4'd1;
        end
    end
endmodule

// File: tb/tb_val2_encoder.sv
// tb_val2_encoder: directed requests with a queue scoreboard checked by an independent monitor.
module tb_val2_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = '0;
    logic        is_mem_command = 1'b0;
    logic        busy, done, valid, immediate;
    logic [11:0] shift_operand;

    val2_encoder dut (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .is_mem_command(is_mem_command), .busy(busy), .done(done),
        .valid(valid), .shift_operand(shift_operand), .immediate(immediate)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        v;
        logic        i;
        logic [11:0] so;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   pass = 0;
    int   total = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) $display("FAIL %s got %h want %h", n, a, e);
        else pass++;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (done) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done got 1 want 0 at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("valid", valid, e.v);
                    chk("immediate", immediate, e.i);
                    chk("shift_operand", shift_operand, e.so);
                    chk("busy_at_done", busy, 1'b0);
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                total++;
                $display("FAIL done_timeout got none want cycle %0d", q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    // Called at a negedge; lat = edges after the accepting edge until done is visible
    task automatic issue(input logic [31:0] v, input logic m, input logic ev, input logic ei,
                         input logic [11:0] eso, input int lat);
        start = 1'b1;
        value = v;
        is_mem_command = m;
        q.push_back('{cyc + 1 + lat, ev, ei, eso});
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, !m);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_so", shift_operand, 12'h000);
        chk("rst_imm", immediate, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        issue(32'h0000_00FF, 1'b0, 1'b1, 1'b1, 12'h0FF, 1);  wait_empty();
        issue(32'hF000_000F, 1'b0, 1'b1, 1'b1, 12'h2FF, 3);  wait_empty();
        issue(32'hFF00_0000, 1'b0, 1'b1, 1'b1, 12'h4FF, 5);  wait_empty();
        issue(32'h0000_03FC, 1'b0, 1'b1, 1'b1, 12'hFFF, 16); wait_empty();
        issue(32'h0000_0101, 1'b0, 1'b0, 1'b0, 12'h000, 16); wait_empty();
        issue(32'h0000_0000, 1'b0, 1'b1, 1'b1, 12'h000, 1);  wait_empty();
        issue(32'hFFFF_F800, 1'b1, 1'b1, 1'b0, 12'h800, 0);  wait_empty();
        issue(32'h0000_0800, 1'b1, 1'b0, 1'b0, 12'h800, 0);  wait_empty();
        issue(32'h0000_07FF, 1'b1, 1'b1, 1'b0, 12'h7FF, 0);  wait_empty();

        // start held and value/mode scrambled during the search
        start = 1'b1;
        value = 32'h0000_03FC;
        is_mem_command = 1'b0;
        q.push_back('{cyc + 17, 1'b1, 1'b1, 12'hFFF});
        repeat (9) begin
            @(negedge clk);
            value = $urandom;
            is_mem_command = 1'b1;
        end
        chk("busy_mid_search", busy, 1'b1);
        start = 1'b0;
        wait_empty();

        // new request accepted in the done cycle
        issue(32'hFF00_0000, 1'b0, 1'b1, 1'b1, 12'h4FF, 5);
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("done_seen", done, 1'b1);
        issue(32'h0000_00FF, 1'b0, 1'b1, 1'b1, 12'h0FF, 1);
        wait_empty();

        // asynchronous reset at rot=5 aborts the search
        issue(32'h0000_0101, 1'b0, 1'b0, 1'b0, 12'h000, 16);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        q.delete();
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_valid", valid, 1'b0);
        chk("abort_so", shift_operand, 12'h000);
        chk("abort_imm", immediate, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("no_done_after_abort", n, 0);
        issue(32'hF000_000F, 1'b0, 1'b1, 1'b1, 12'h2FF, 3);
        wait_empty();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
